// File: rtl/rv32ima_mem_arbiter.sv
// rv32ima_mem_arbiter: two-master arbiter in front of the shared single-port memory.
// M0 is the instruction fetch port and M1 is the load/store/AMO port.
// M1 normally has priority. A starvation counter bounds how long a waiting
// fetch can be held off. An M1 lock keeps the bus on M1 across an
// A-extension read-modify-write sequence.
// Responses have a fixed latency. They are steered back to the issuing
// master by a tag shift register that is LATENCY stages deep.
module rv32ima_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic [DW-1:0]   m1_wdata,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_req,
  output logic [AW-1:0]   s_addr,
  output logic            s_we,
  output logic [DW/8-1:0] s_wstrb,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_ready,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t             state, state_next;
  logic [3:0]         starve_cnt, starve_next;
  logic               win_m0, win_m1;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_id;

  // Winner selection: while locked only M1 may win; otherwise M1 wins unless fetch has starved
  always_comb begin
    win_m0 = 1'b0;
    win_m1 = 1'b0;
    if (!rst) begin
      if (state == LOCKED) begin
        win_m1 = m1_req;
      end else if (m0_req && m1_req) begin
        if (starve_cnt == STARVE_LIM) win_m0 = 1'b1;
        else                          win_m1 = 1'b1;
      end else begin
        win_m0 = m0_req;
        win_m1 = m1_req;
      end
    end
  end

  // Forward the winner's request fields to memory; grants only complete when memory is ready
  always_comb begin
    s_req   = win_m0 | win_m1;
    s_addr  = win_m1 ? m1_addr : m0_addr;
    s_we    = win_m1 & m1_we;
    s_wstrb = win_m1 ? m1_wstrb : '0;
    s_wdata = m1_wdata;
    m0_gnt  = win_m0 & s_ready;
    m1_gnt  = win_m1 & s_ready;
  end

  // Lock FSM and starvation counter next-state; both only move on cycles where memory is ready
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    if (m1_gnt) begin
      state_next = m1_lock ? LOCKED : IDLE;
    end
    if (s_ready && state == IDLE) begin
      if (m0_gnt || !m0_req) begin
        starve_next = 4'd0;
      end else if (m1_gnt && starve_cnt != STARVE_LIM) begin
        starve_next = starve_cnt + 4'd1;
      end
    end
  end

  // Lock FSM and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Tag pipe: records which master owns each in-flight access; cleared on reset so stale responses are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= s_req & s_ready;
      tag_id[0]    <= win_m1;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // Response steering: the oldest tag decides which master sees s_rvalid; data goes to both
  always_comb begin
    m0_rvalid = !rst && s_rvalid && tag_valid[LATENCY-1] && !tag_id[LATENCY-1];
    m1_rvalid = !rst && s_rvalid && tag_valid[LATENCY-1] &&  tag_id[LATENCY-1];
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
  end

endmodule

// File: tb/tb_rv32ima_mem_arbiter.sv
// tb_rv32ima_mem_arbiter: directed vector bench for the memory arbiter.
// Instance A runs with LATENCY=1 and instance B runs with LATENCY=3. Both
// share the master-side stimulus, and each has its own fixed-latency memory
// model whose read data is a function of the address.
module tb_rv32ima_mem_arbiter;

  typedef struct {
    logic        rst;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic        m1_lock;
    logic        s_ready;
    logic        g0;
    logic        g1;
    logic        rv0;
    logic        rv1;
    logic [31:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0, s_ready = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wstrb = '0;

  logic        m0_gnt_a, m0_rvalid_a, m1_gnt_a, m1_rvalid_a, s_req_a, s_we_a;
  logic [31:0] m0_rdata_a, m1_rdata_a, s_addr_a, s_wdata_a;
  logic [3:0]  s_wstrb_a;
  logic        s_rvalid_a = 1'b0;
  logic [31:0] s_rdata_a = '0;

  logic        m0_gnt_b, m0_rvalid_b, m1_gnt_b, m1_rvalid_b, s_req_b, s_we_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, s_addr_b, s_wdata_b;
  logic [3:0]  s_wstrb_b;
  logic [2:0]  pv_b = '0;
  logic [31:0] pd_b [3];

  int vectors_applied = 0;
  int miscompares = 0;

  vec_t tbl[$];
  vec_t hseq[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A00_C3C3;
  endfunction

  rv32ima_mem_arbiter #(.AW(32), .DW(32), .LATENCY(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
    .s_req(s_req_a), .s_addr(s_addr_a), .s_we(s_we_a), .s_wstrb(s_wstrb_a), .s_wdata(s_wdata_a),
    .s_ready(s_ready), .s_rvalid(s_rvalid_a), .s_rdata(s_rdata_a)
  );

  rv32ima_mem_arbiter #(.AW(32), .DW(32), .LATENCY(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b),
    .s_req(s_req_b), .s_addr(s_addr_b), .s_we(s_we_b), .s_wstrb(s_wstrb_b), .s_wdata(s_wdata_b),
    .s_ready(s_ready), .s_rvalid(pv_b[2]), .s_rdata(pd_b[2])
  );

  // Memory models: never reset, so responses to accesses flushed by reset still arrive
  always @(posedge clk) begin
    s_rvalid_a <= s_req_a & s_ready;
    s_rdata_a  <= mdata(s_addr_a);
    pv_b       <= {pv_b[1:0], s_req_b & s_ready};
    pd_b[0]    <= mdata(s_addr_b);
    pd_b[1]    <= pd_b[0];
    pd_b[2]    <= pd_b[1];
  end

  function automatic vec_t mk(input logic r, input logic q0, input logic [31:0] a0,
                              input logic q1, input logic [31:0] a1, input logic we,
                              input logic lk, input logic rdy, input logic g0, input logic g1,
                              input logic rv0, input logic rv1, input logic [31:0] d);
    vec_t v;
    v.rst = r;   v.m0_req = q0; v.m0_addr = a0; v.m1_req = q1; v.m1_addr = a1;
    v.m1_we = we; v.m1_lock = lk; v.s_ready = rdy;
    v.g0 = g0;   v.g1 = g1;     v.rv0 = rv0;    v.rv1 = rv1;   v.data = d;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst      = v.rst;
    m0_req   = v.m0_req;
    m0_addr  = v.m0_addr;
    m1_req   = v.m1_req;
    m1_addr  = v.m1_addr;
    m1_we    = v.m1_we;
    m1_lock  = v.m1_lock;
    s_ready  = v.s_ready;
    m1_wstrb = v.m1_we ? 4'hF : 4'h0;
    m1_wdata = 32'hDEAD_0000 | v.m1_addr;
    #1;
    vectors_applied++;
  endtask

  task automatic checkOutput(input vec_t v, input int idx, input bit use_b, input string name);
    logic [3:0]  got, want;
    logic [31:0] rd;
    if (use_b) begin
      got = {m0_gnt_b, m1_gnt_b, m0_rvalid_b, m1_rvalid_b};
      rd  = v.rv0 ? m0_rdata_b : m1_rdata_b;
    end else begin
      got = {m0_gnt_a, m1_gnt_a, m0_rvalid_a, m1_rvalid_a};
      rd  = v.rv0 ? m0_rdata_a : m1_rdata_a;
    end
    want = {v.g0, v.g1, v.rv0, v.rv1};
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s vec %0d {g0,g1,rv0,rv1}: got %b expected %b", name, idx, got, want);
    end
    if ((v.rv0 || v.rv1) && rd !== v.data) begin
      miscompares++;
      $display("[TB] FAIL %s vec %0d rdata: got %h expected %h", name, idx, rd, v.data);
    end
  endtask

  initial begin
    // LATENCY=1 table. Fields: rst,m0_req,m0_addr,m1_req,m1_addr,we,lock,ready | g0,g1,rv0,rv1,data
    // reset forces grants low even with requests pending
    tbl.push_back(mk(1,1,32'h0,1,32'h0,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,0,0,1, 0,0,0,0,0));
    // fetch-only stream 0x0,0x4,0x8
    tbl.push_back(mk(0,1,32'h0,0,32'h0,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(0,1,32'h4,0,32'h0,0,0,1, 1,0,1,0,mdata(32'h0)));
    tbl.push_back(mk(0,1,32'h8,0,32'h0,0,0,1, 1,0,1,0,mdata(32'h4)));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,1,0,mdata(32'h8)));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,0,0,0));
    // both requesting: M1 x4 then M0, twice
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 0,1,0,1,mdata(32'h200)));
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 0,1,0,1,mdata(32'h200)));
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 0,1,0,1,mdata(32'h200)));
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 1,0,0,1,mdata(32'h200)));
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 0,1,1,0,mdata(32'h10)));
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 0,1,0,1,mdata(32'h200)));
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 0,1,0,1,mdata(32'h200)));
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 0,1,0,1,mdata(32'h200)));
    tbl.push_back(mk(0,1,32'h10,1,32'h200,0,0,1, 1,0,0,1,mdata(32'h200)));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,1,0,mdata(32'h10)));
    // stall at count 3: counter must hold, M1 resumes, then M0
    tbl.push_back(mk(0,1,32'h14,1,32'h204,0,0,1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,32'h14,1,32'h204,0,0,1, 0,1,0,1,mdata(32'h204)));
    tbl.push_back(mk(0,1,32'h14,1,32'h204,0,0,1, 0,1,0,1,mdata(32'h204)));
    tbl.push_back(mk(0,1,32'h14,1,32'h204,0,0,0, 0,0,0,1,mdata(32'h204)));
    tbl.push_back(mk(0,1,32'h14,1,32'h204,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h14,1,32'h204,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h14,1,32'h204,0,0,1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,32'h14,1,32'h204,0,0,1, 1,0,0,1,mdata(32'h204)));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,1,0,mdata(32'h14)));
    // AMO read(lock) + write(unlock) with fetch waiting
    tbl.push_back(mk(0,1,32'h18,1,32'h100,0,1,1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,32'h18,1,32'h100,1,0,1, 0,1,0,1,mdata(32'h100)));
    tbl.push_back(mk(0,1,32'h18,0,32'h0,0,0,1, 1,0,0,1,mdata(32'h100)));
    // AMO with an idle M1 cycle inside the lock: fetch still blocked
    tbl.push_back(mk(0,1,32'h18,1,32'h104,0,1,1, 0,1,1,0,mdata(32'h18)));
    tbl.push_back(mk(0,1,32'h18,0,32'h0,0,0,1, 0,0,0,1,mdata(32'h104)));
    tbl.push_back(mk(0,1,32'h18,1,32'h104,1,0,1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,32'h18,0,32'h0,0,0,1, 1,0,0,1,mdata(32'h104)));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,1,0,mdata(32'h18)));
    // lock on an ungranted access must not lock the bus
    tbl.push_back(mk(0,1,32'h1C,1,32'h108,0,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1C,0,32'h0,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,1,0,mdata(32'h1C)));
    // M1 write then M0 read: responses in grant order, one per cycle
    tbl.push_back(mk(0,0,32'h0,1,32'h300,1,0,1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,32'h20,0,32'h0,0,0,1, 1,0,0,1,mdata(32'h300)));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,1,0,mdata(32'h20)));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,0,0,0));

    // LATENCY=3 sequence: interleaved traffic, then reset with two accesses in flight
    hseq.push_back(mk(1,0,32'h0,0,32'h0,0,0,1, 0,0,0,0,0));
    hseq.push_back(mk(0,1,32'h40,0,32'h0,0,0,1, 1,0,0,0,0));
    hseq.push_back(mk(0,0,32'h0,1,32'h80,0,0,1, 0,1,0,0,0));
    hseq.push_back(mk(0,1,32'h44,0,32'h0,0,0,1, 1,0,0,0,0));
    hseq.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,1,0,mdata(32'h40)));
    hseq.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,0,1,mdata(32'h80)));
    hseq.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,1,0,mdata(32'h44)));
    hseq.push_back(mk(0,1,32'h48,0,32'h0,0,0,1, 1,0,0,0,0));
    hseq.push_back(mk(0,1,32'h4C,1,32'h84,0,1,1, 0,1,0,0,0));
    hseq.push_back(mk(1,1,32'h4C,1,32'h84,0,0,1, 0,0,0,0,0));
    hseq.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,0,0,0));
    hseq.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,0,0,0));
    // after reset: unlocked and count at zero, so M1 x4 then M0
    hseq.push_back(mk(0,1,32'h50,1,32'h88,0,0,1, 0,1,0,0,0));
    hseq.push_back(mk(0,1,32'h50,1,32'h88,0,0,1, 0,1,0,0,0));
    hseq.push_back(mk(0,1,32'h50,1,32'h88,0,0,1, 0,1,0,0,0));
    hseq.push_back(mk(0,1,32'h50,1,32'h88,0,0,1, 0,1,0,1,mdata(32'h88)));
    hseq.push_back(mk(0,1,32'h50,1,32'h88,0,0,1, 1,0,0,1,mdata(32'h88)));
    hseq.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,0,1,mdata(32'h88)));
    hseq.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,0,1,mdata(32'h88)));
    hseq.push_back(mk(0,0,32'h0,0,32'h0,0,0,1, 0,0,1,0,mdata(32'h50)));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], i, 1'b0, "lat1");
    end
    foreach (hseq[i]) begin
      applyStimulus(hseq[i]);
      checkOutput(hseq[i], i, 1'b1, "lat3");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
